cmp_window_max: RTL and testbench

- Sequential window-maximum finder built around the 4-bit magnitude comparator.
- Accepts a valid/ready stream of 4-bit samples and drives comparator operands A = incoming sample, B = running max.
- Consumes the comparator's gt/eq/lt flags to update the running max, its index and a tie count.
- After WIN samples, presents the result on a valid/ready output port, then starts the next window.

---
 rtl/cmp_window_max_if.sv | 25 ++
 rtl/cmp_window_max.sv | 71 +++++++
 tb/tb_cmp_window_max.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cmp_window_max_if.sv
// cmp_window_max_if: sample stream, comparator operands/flags and result port of cmp_window_max
interface cmp_window_max_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_gt;
  logic       cmp_eq;
  logic       cmp_lt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_max;
  logic [3:0] out_idx;
  logic [3:0] out_ties;
  logic       cmp_err;
  modport master (
    output in_valid, in_data, cmp_gt, cmp_eq, cmp_lt, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, out_max, out_idx, out_ties, cmp_err
  );
  modport slave (
    input  in_valid, in_data, cmp_gt, cmp_eq, cmp_lt, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, out_max, out_idx, out_ties, cmp_err
  );
endinterface

// File: rtl/cmp_window_max.sv
// cmp_window_max: running max/first index/tie count over WIN samples using an external comparator; define CMP_CHECK_EN for a sticky one-hot flag check
module cmp_window_max #(
  parameter int WIN = 8
) (
  input logic            clk,
  input logic            rst,
  cmp_window_max_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_max, r_idx, r_ties, r_cnt;
  logic       w_acc, w_last;
  assign bus.in_ready  = (r_state != DONE);
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_last        = (r_cnt == 4'(WIN - 1));
  assign bus.cmp_a     = bus.in_data;
  assign bus.cmp_b     = r_max;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_max   = r_max;
  assign bus.out_idx   = r_idx;
  assign bus.out_ties  = r_ties;
  // next state: first sample starts the window, sample WIN-1 closes it, result handshake reopens
  always_comb begin
    w_next = (r_state == IDLE && w_acc) ? ((WIN == 1) ? DONE : RUN) :
             (r_state == RUN && w_acc && w_last) ? DONE :
             (r_state == DONE && bus.out_ready) ? IDLE : r_state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // window datapath: gt replaces max (priority over eq), eq counts a tie, lt holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max  <= '0;
      r_idx  <= '0;
      r_ties <= '0;
      r_cnt  <= '0;
    end else if (r_state == IDLE && w_acc) begin
      r_max  <= bus.in_data;
      r_idx  <= '0;
      r_ties <= '0;
      r_cnt  <= 4'(WIN > 1);
    end else if (r_state == RUN && w_acc) begin
      if (bus.cmp_gt) begin
        r_max  <= bus.in_data;
        r_idx  <= r_cnt;
        r_ties <= '0;
      end else if (bus.cmp_eq) begin
        r_ties <= r_ties + 4'd1;
      end
      r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
    end else if (r_state == DONE && bus.out_ready) begin
      r_cnt <= '0;
    end
  end
`ifdef CMP_CHECK_EN
  logic r_err;
  // sticky error whenever a RUN accept sees comparator flags that are not exactly one-hot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (r_state == RUN && w_acc && !$onehot({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt})) r_err <= 1'b1;
  end
  assign bus.cmp_err = r_err;
`else
  logic w_unused_lt;
  assign w_unused_lt = bus.cmp_lt;
  assign bus.cmp_err = 1'b0;
`endif
endmodule

// File: tb/tb_cmp_window_max.sv
// tb_cmp_window_max: directed checks of cmp_window_max (WIN=4 and WIN=8) with a behavioural comparator
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end
module tb_cmp_window_max;
  logic clk, rst, bad4;
  logic done = 1'b0;
  int   checks = 0;
  int   failures = 0;
  cmp_window_max_if b4 ();
  cmp_window_max_if b8 ();
  cmp_window_max #(.WIN(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  cmp_window_max #(.WIN(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  assign b4.cmp_gt = bad4 | (b4.cmp_a > b4.cmp_b);
  assign b4.cmp_eq = bad4 | (b4.cmp_a == b4.cmp_b);
  assign b4.cmp_lt = !bad4 & (b4.cmp_a < b4.cmp_b);
  assign b8.cmp_gt = b8.cmp_a > b8.cmp_b;
  assign b8.cmp_eq = b8.cmp_a == b8.cmp_b;
  assign b8.cmp_lt = b8.cmp_a < b8.cmp_b;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    if (!done) begin
      failures++;
      $error("FAIL timeout: test sequence did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send4(input logic [3:0] d);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    tick();
    b4.in_valid = 1'b0;
  endtask
  task automatic send8(input logic [3:0] d);
    b8.in_valid = 1'b1;
    b8.in_data  = d;
    tick();
    b8.in_valid = 1'b0;
  endtask
  task automatic win4(input string tag, input logic [3:0] d0, d1, d2, d3, m, i, t);
    send4(d0);
    send4(d1);
    send4(d2);
    `CHK({tag, "_early"}, b4.out_valid, 1'b0)
    send4(d3);
    `CHK({tag, "_valid"}, b4.out_valid, 1'b1)
    `CHK({tag, "_res"}, ({b4.out_max, b4.out_idx, b4.out_ties}), ({m, i, t}))
  endtask
  initial begin
    logic [3:0] d [8];
    logic [3:0] m, i, t;
    logic       e_err;
`ifdef CMP_CHECK_EN
    e_err = 1'b1;
`else
    e_err = 1'b0;
`endif
    rst = 1'b1;
    bad4 = 1'b0;
    b4.in_valid = 1'b0;
    b4.in_data = 4'd0;
    b4.out_ready = 1'b1;
    b8.in_valid = 1'b0;
    b8.in_data = 4'd0;
    b8.out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({b4.out_valid, b4.cmp_err, b4.in_ready} !== 3'b001) begin
      failures++;
      $error("FAIL rst_ctl observed=%0h expected=1", {b4.out_valid, b4.cmp_err, b4.in_ready});
    end
    checks++;
    if ({b4.cmp_b, b4.out_max, b4.out_idx, b4.out_ties} !== 16'h0000) begin
      failures++;
      $error("FAIL rst_vals observed=%0h expected=0", {b4.cmp_b, b4.out_max, b4.out_idx, b4.out_ties});
    end
    rst = 1'b0;
    win4("w1", 4'd3, 4'd9, 4'd2, 4'd9, 4'd9, 4'd1, 4'd1);
    tick();
    `CHK("w1_ack", ({b4.out_valid, b4.in_ready}), 2'b01)
    b4.in_data = 4'd6;
    #1;
    `CHK("cmp_ops", ({b4.cmp_a, b4.cmp_b}), 8'h69)
    win4("w2", 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd3);
    tick();
    win4("w3", 4'd0, 4'd1, 4'd2, 4'd15, 4'd15, 4'd3, 4'd0);
    tick();
    b4.out_ready = 1'b0;
    win4("w4", 4'd4, 4'd8, 4'd8, 4'd1, 4'd8, 4'd1, 4'd1);
    for (int k = 0; k < 5; k++) begin
      b4.in_valid = 1'b1;
      b4.in_data = 4'd15;
      tick();
      checks++;
      if ({b4.in_ready, b4.out_valid, b4.out_max, b4.out_idx, b4.out_ties} !== 14'b01_1000_0001_0001) begin
        failures++;
        $error("FAIL hold cycle %0d observed=%0h", k, {b4.in_ready, b4.out_valid, b4.out_max, b4.out_idx, b4.out_ties});
      end
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    tick();
    `CHK("release", ({b4.out_valid, b4.in_ready}), 2'b01)
    send4(4'd12);
    send4(4'd13);
    rst = 1'b1;
    #1;
    `CHK("mid_rst", ({b4.out_valid, b4.cmp_b, b4.out_max, b4.out_idx, b4.out_ties}), 17'd0)
    #2;
    rst = 1'b0;
    win4("w5", 4'd7, 4'd1, 4'd1, 4'd1, 4'd7, 4'd0, 4'd0);
    tick();
    send4(4'd3);
    bad4 = 1'b1;
    send4(4'd5);
    bad4 = 1'b0;
    send4(4'd2);
    send4(4'd1);
    `CHK("bad_res", ({b4.out_valid, b4.out_max, b4.out_idx, b4.out_ties}), 13'b1_0101_0001_0000)
    `CHK("bad_err", b4.cmp_err, e_err)
    tick();
    tick();
    `CHK("err_sticky", b4.cmp_err, e_err)
    rst = 1'b1;
    #1;
    `CHK("err_clr", b4.cmp_err, 1'b0)
    #2;
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 8; k++) d[k] = 4'($urandom_range(0, 7));
      m = d[0];
      i = 4'd0;
      t = 4'd0;
      for (int k = 1; k < 8; k++) begin
        if (d[k] > m) begin
          m = d[k];
          i = 4'(k);
          t = 4'd0;
        end else if (d[k] == m) begin
          t = t + 4'd1;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 1) == 1) tick();
        if (k == 7) `CHK("w8_early", b8.out_valid, 1'b0)
        send8(d[k]);
      end
      `CHK("w8_res", ({b8.out_valid, b8.out_max, b8.out_idx, b8.out_ties}), ({1'b1, m, i, t}))
      tick();
      `CHK("w8_ack", ({b8.out_valid, b8.in_ready}), 2'b01)
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
